// File: rtl/proc_sched_pkg.sv
// Shared types and constants for the round-robin process scheduler.
package proc_sched_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REQ    = 2'd1,
        SWAP   = 2'd2,
        KERNEL = 2'd3
    } sched_state_e;

    localparam int KERNEL_PROC     = 0;
    localparam int DEFAULT_QUANTUM = 100;

    function automatic int default_quantum();
        return DEFAULT_QUANTUM;
    endfunction

endpackage

// File: rtl/proc_scheduler_rr_picker.sv
// Combinational round-robin search: first ready index above start_i, wrapping,
// never returning the kernel slot 0; next_o=0/found_o=0 when nothing is ready.
module rr_picker #(
    parameter int PROC_WIDTH = 6,
    parameter int NUM_PROCS  = 64
) (
    input  logic [NUM_PROCS-1:0]  ready_mask_i,
    input  logic [PROC_WIDTH-1:0] start_i,
    output logic [PROC_WIDTH-1:0] next_o,
    output logic                  found_o
);

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        // Upper half first (above start), then wrap to 1..start.
        for (int j = 1; j < NUM_PROCS; j++) begin
            if (!found_o && j > int'(start_i) && ready_mask_i[j]) begin
                found_o = 1'b1;
                next_o  = PROC_WIDTH'(j);
            end
        end
        for (int j = 1; j < NUM_PROCS; j++) begin
            if (!found_o && j <= int'(start_i) && ready_mask_i[j]) begin
                found_o = 1'b1;
                next_o  = PROC_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/proc_scheduler.sv
// Time-sliced round-robin scheduler driving the process keeper's swap interface.
// Optional SCHED_QUANTUM_CFG_EN adds a run-time writable quantum reload value.
module proc_scheduler
    import proc_sched_pkg::*;
#(
    parameter int PROC_WIDTH = 6,
    parameter int NUM_PROCS  = 64,
    parameter int QWIDTH     = 8,
    parameter int QUANTUM    = default_quantum()
) (
    input  logic                  single_clk,
    input  logic                  rst,
    input  logic                  true_intrpt,
    input  logic                  intrpt_done,
    input  logic                  proc_set_ready,
    input  logic                  proc_clr_ready,
    input  logic [PROC_WIDTH-1:0] proc_id,
    input  logic                  yield,
    input  logic                  swap_ack,
    output logic                  swap_req,
    output logic                  proc_swap,
    output logic [PROC_WIDTH-1:0] new_proc_num,
    output logic [PROC_WIDTH-1:0] cur_proc,
    output logic [NUM_PROCS-1:0]  ready_mask,
    output logic                  idle
`ifdef SCHED_QUANTUM_CFG_EN
    ,
    input  logic                  cfg_quantum_we,
    input  logic [QWIDTH-1:0]     cfg_quantum
`endif
);

    localparam logic [QWIDTH-1:0] QLOAD = QWIDTH'(QUANTUM);

    sched_state_e          state_q, state_d;
    logic [PROC_WIDTH-1:0] cur_q, cur_d;
    logic [PROC_WIDTH-1:0] new_q, new_d;
    logic [PROC_WIDTH-1:0] saved_q, saved_d;
    logic [QWIDTH-1:0]     cnt_q, cnt_d;
    logic [NUM_PROCS-1:0]  ready_q, ready_d;
    logic [QWIDTH-1:0]     reload_val;

    logic                  cur_rdy, new_rdy, saved_rdy;
    logic [PROC_WIDTH-1:0] pick_start, pick;
    logic                  pick_found;

`ifdef SCHED_QUANTUM_CFG_EN
    logic [QWIDTH-1:0] reload_q;
    always_ff @(posedge single_clk) begin
        if (rst) begin
            reload_q <= QLOAD;
        end else if (cfg_quantum_we && cfg_quantum != '0) begin
            reload_q <= cfg_quantum;
        end
    end
    assign reload_val = reload_q;
`else
    assign reload_val = QLOAD;
`endif

    // Ready table: slot 0 is always ready; clr is applied after set so it wins.
    always_comb begin
        ready_d = ready_q;
        for (int j = 1; j < NUM_PROCS; j++) begin
            if (int'(proc_id) == j) begin
                if (proc_set_ready) ready_d[j] = 1'b1;
                if (proc_clr_ready) ready_d[j] = 1'b0;
            end
        end
        ready_d[0] = 1'b1;
    end

    always_comb begin
        cur_rdy   = 1'b0;
        new_rdy   = 1'b0;
        saved_rdy = 1'b0;
        for (int j = 0; j < NUM_PROCS; j++) begin
            if (int'(cur_q) == j)   cur_rdy   = ready_q[j];
            if (int'(new_q) == j)   new_rdy   = ready_q[j];
            if (int'(saved_q) == j) saved_rdy = ready_q[j];
        end
    end

    // Kernel resumes the search from the interrupted process, others from cur.
    assign pick_start = (state_q == KERNEL) ? saved_q : cur_q;

    rr_picker #(
        .PROC_WIDTH (PROC_WIDTH),
        .NUM_PROCS  (NUM_PROCS)
    ) u_picker (
        .ready_mask_i (ready_q),
        .start_i      (pick_start),
        .next_o       (pick),
        .found_o      (pick_found)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        new_d   = new_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        if (true_intrpt) begin
            if (state_q != KERNEL) begin
                saved_d = (state_q == SWAP) ? new_q : cur_q;
                cur_d   = PROC_WIDTH'(KERNEL_PROC);
                state_d = KERNEL;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (cnt_q <= QWIDTH'(1) || yield || !cur_rdy) begin
                        if (pick == cur_q) begin
                            cnt_d = reload_val;
                        end else begin
                            new_d   = pick;
                            state_d = REQ;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                REQ: begin
                    // A target that lost readiness is replaced before any ack is honoured.
                    if (!new_rdy) begin
                        if (pick == cur_q) begin
                            cnt_d   = reload_val;
                            state_d = RUN;
                        end else begin
                            new_d = pick;
                        end
                    end else if (swap_ack) begin
                        state_d = SWAP;
                    end
                end
                SWAP: begin
                    cur_d   = new_q;
                    cnt_d   = reload_val;
                    state_d = RUN;
                end
                KERNEL: begin
                    if (intrpt_done) begin
                        if (saved_q != '0 && saved_rdy) begin
                            new_d   = saved_q;
                            state_d = REQ;
                        end else if (pick_found) begin
                            new_d   = pick;
                            state_d = REQ;
                        end else begin
                            new_d   = PROC_WIDTH'(KERNEL_PROC);
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge single_clk) begin
        if (rst) begin
            state_q <= RUN;
            cur_q   <= '0;
            new_q   <= '0;
            saved_q <= '0;
            cnt_q   <= QLOAD;
            ready_q <= NUM_PROCS'(1);
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            new_q   <= new_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign swap_req     = (state_q == REQ);
    assign proc_swap    = (state_q == SWAP);
    assign new_proc_num = new_q;
    assign cur_proc     = cur_q;
    assign ready_mask   = ready_q;
    assign idle         = ~|ready_q[NUM_PROCS-1:1];

endmodule

// File: tb/tb_proc_scheduler.sv
// Directed bench for proc_scheduler with QUANTUM=4; expected values are hand-derived.
module tb_proc_scheduler;

    logic        single_clk = 1'b0;
    logic        rst, true_intrpt, intrpt_done, proc_set_ready, proc_clr_ready;
    logic [5:0]  proc_id;
    logic        yield, swap_ack;
    logic        swap_req, proc_swap, idle;
    logic [5:0]  new_proc_num, cur_proc;
    logic [63:0] ready_mask;
`ifdef SCHED_QUANTUM_CFG_EN
    logic        cfg_quantum_we;
    logic [7:0]  cfg_quantum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 single_clk = ~single_clk;

    proc_scheduler #(
        .PROC_WIDTH (6),
        .NUM_PROCS  (64),
        .QWIDTH     (8),
        .QUANTUM    (4)
    ) dut (
        .single_clk     (single_clk),
        .rst            (rst),
        .true_intrpt    (true_intrpt),
        .intrpt_done    (intrpt_done),
        .proc_set_ready (proc_set_ready),
        .proc_clr_ready (proc_clr_ready),
        .proc_id        (proc_id),
        .yield          (yield),
        .swap_ack       (swap_ack),
        .swap_req       (swap_req),
        .proc_swap      (proc_swap),
        .new_proc_num   (new_proc_num),
        .cur_proc       (cur_proc),
        .ready_mask     (ready_mask),
        .idle           (idle)
`ifdef SCHED_QUANTUM_CFG_EN
        ,
        .cfg_quantum_we (cfg_quantum_we),
        .cfg_quantum    (cfg_quantum)
`endif
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge single_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ack a pending request and land on the new process.
    task automatic do_swap(input logic [5:0] exp_cur);
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        chk("swap_strobe", proc_swap, 1'b1);
        chk("swap_req_drop", swap_req, 1'b0);
        tick();
        chk("swap_cur", cur_proc, exp_cur);
        chk("swap_strobe_end", proc_swap, 1'b0);
    endtask

    initial begin
        rst = 1'b1; true_intrpt = 1'b0; intrpt_done = 1'b0;
        proc_set_ready = 1'b0; proc_clr_ready = 1'b0; proc_id = '0;
        yield = 1'b0; swap_ack = 1'b0;
`ifdef SCHED_QUANTUM_CFG_EN
        cfg_quantum_we = 1'b0; cfg_quantum = '0;
`endif
        tick(2);
        chk("rst_swap_req", swap_req, 1'b0);
        chk("rst_proc_swap", proc_swap, 1'b0);
        chk("rst_cur", cur_proc, 6'd0);
        chk("rst_new", new_proc_num, 6'd0);
        chk("rst_ready", ready_mask, 64'h1);
        chk("rst_idle", idle, 1'b1);

        // Quantum 4 from reset release: request appears on the 4th edge.
        rst = 1'b0; proc_set_ready = 1'b1; proc_id = 6'd3;
        tick();
        proc_id = 6'd5;
        tick();
        proc_set_ready = 1'b0;
        chk("ready_3_5", ready_mask, 64'h29);
        chk("idle_busy", idle, 1'b0);
        tick();
        chk("no_req_early", swap_req, 1'b0);
        tick();
        chk("req_first", swap_req, 1'b1);
        chk("req_first_num", new_proc_num, 6'd3);
        chk("cur_before_swap", cur_proc, 6'd0);
        do_swap(6'd3);

        tick(3);
        chk("slice3_no_req", swap_req, 1'b0);
        tick();
        chk("slice3_req", swap_req, 1'b1);
        chk("slice3_next", new_proc_num, 6'd5);
        do_swap(6'd5);
        tick(4);
        chk("wrap_req", swap_req, 1'b1);
        chk("wrap_next", new_proc_num, 6'd3);
        do_swap(6'd3);

        // Yield from 3, then hold the ack off for 10 cycles.
        yield = 1'b1;
        tick();
        yield = 1'b0;
        chk("yield_req", swap_req, 1'b1);
        chk("yield_next", new_proc_num, 6'd5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_req", swap_req, 1'b1);
            chk("hold_num", new_proc_num, 6'd5);
        end
        do_swap(6'd5);

        // Back to 3, then interrupt while requesting 3->5.
        yield = 1'b1; tick(); yield = 1'b0;
        do_swap(6'd3);
        yield = 1'b1; tick(); yield = 1'b0;
        chk("pre_int_next", new_proc_num, 6'd5);
        true_intrpt = 1'b1;
        tick();
        true_intrpt = 1'b0;
        chk("int_cur", cur_proc, 6'd0);
        chk("int_req", swap_req, 1'b0);
        tick(3);
        chk("kernel_no_req", swap_req, 1'b0);
        intrpt_done = 1'b1;
        tick();
        intrpt_done = 1'b0;
        chk("resume_req", swap_req, 1'b1);
        chk("resume_saved", new_proc_num, 6'd3);
        do_swap(6'd3);

        // Same, but the saved process is cleared while in the kernel.
        yield = 1'b1; tick(); yield = 1'b0;
        true_intrpt = 1'b1; tick(); true_intrpt = 1'b0;
        proc_clr_ready = 1'b1; proc_id = 6'd3;
        tick();
        proc_clr_ready = 1'b0;
        chk("clr3_mask", ready_mask, 64'h21);
        intrpt_done = 1'b1;
        tick();
        intrpt_done = 1'b0;
        chk("resume_rr_req", swap_req, 1'b1);
        chk("resume_rr_num", new_proc_num, 6'd5);
        do_swap(6'd5);

        // Make 7 the only user process: clearing running 5 forces a request.
        proc_set_ready = 1'b1; proc_id = 6'd7; tick(); proc_set_ready = 1'b0;
        proc_clr_ready = 1'b1; proc_id = 6'd5; tick(); proc_clr_ready = 1'b0;
        chk("clr_run_wait", swap_req, 1'b0);
        tick();
        chk("clr_run_req", swap_req, 1'b1);
        chk("clr_run_num", new_proc_num, 6'd7);
        do_swap(6'd7);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("solo_no_req", swap_req, 1'b0);
            chk("solo_no_swap", proc_swap, 1'b0);
        end
        chk("solo_cur", cur_proc, 6'd7);

        // Ready-table corner cases.
        proc_set_ready = 1'b1; proc_clr_ready = 1'b1; proc_id = 6'd9;
        tick();
        proc_set_ready = 1'b0;
        proc_id = 6'd0;
        tick();
        proc_clr_ready = 1'b0;
        chk("setclr_9_and_clr_0", ready_mask, 64'h81);

        // Clear the last user process: request for kernel process 0.
        proc_clr_ready = 1'b1; proc_id = 6'd7; tick(); proc_clr_ready = 1'b0;
        chk("idle_set", idle, 1'b1);
        tick();
        chk("idle_req", swap_req, 1'b1);
        chk("idle_num", new_proc_num, 6'd0);
        do_swap(6'd0);
        tick(6);
        chk("idle_no_req", swap_req, 1'b0);
        chk("idle_still", idle, 1'b1);

        // Reset from inside a pending request.
        proc_set_ready = 1'b1; proc_id = 6'd3; tick(); proc_set_ready = 1'b0;
        yield = 1'b1; tick(); yield = 1'b0;
        chk("prerst_req", swap_req, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst2_req", swap_req, 1'b0);
        chk("rst2_ready", ready_mask, 64'h1);
        chk("rst2_new", new_proc_num, 6'd0);
        rst = 1'b0;

`ifdef SCHED_QUANTUM_CFG_EN
        proc_set_ready = 1'b1; proc_id = 6'd3; tick();
        proc_id = 6'd5; tick(); proc_set_ready = 1'b0;
        tick(2);
        chk("cfg_req3", new_proc_num, 6'd3);
        do_swap(6'd3);
        tick();
        cfg_quantum_we = 1'b1; cfg_quantum = 8'd2;
        tick();
        cfg_quantum_we = 1'b0;
        tick();
        chk("cfg_old_slice", swap_req, 1'b0);
        tick();
        chk("cfg_old_end", swap_req, 1'b1);
        do_swap(6'd5);
        cfg_quantum_we = 1'b1; cfg_quantum = 8'd0;
        tick();
        cfg_quantum_we = 1'b0;
        chk("cfg_new_mid", swap_req, 1'b0);
        tick();
        chk("cfg_new_end", swap_req, 1'b1);
        do_swap(6'd3);
        tick();
        chk("cfg_zero_mid", swap_req, 1'b0);
        tick();
        chk("cfg_zero_end", swap_req, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_scheduler.md
Name: proc_scheduler

Overview:
- Round-robin, time-sliced process scheduler that drives the process keeper's proc_swap/new_proc_num inputs.
- Keeps a ready table of processes and a per-process quantum counter.
- Asks the core for a swap at quantum expiry, yield or descheduling, and issues the swap only after the core acknowledges a safe instruction boundary.
- Mirrors the interrupt path: true_intrpt forces kernel process 0, and intrpt_done resumes user scheduling.

Parameters:
- PROC_WIDTH, 6: width of process numbers.
- NUM_PROCS, 64: number of schedulable processes, ≤ 2^PROC_WIDTH; process 0 is the kernel.
- QWIDTH, 8: width of the quantum counter.
- QUANTUM, 100: default time slice in cycles, 1..2^QWIDTH-1.

Ports:
- single_clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- true_intrpt  in  1  interrupt taken; the keeper jumps to process 0.
- intrpt_done  in  1  kernel finished the interrupt; resume user scheduling.
- proc_set_ready  in  1  mark proc_id ready.
- proc_clr_ready  in  1  mark proc_id not ready.
- proc_id  in  PROC_WIDTH  target of set/clr.
- yield  in  1  current process gives up the rest of its quantum.
- swap_ack  in  1  core at a safe boundary; swap permitted.
- swap_req  out  1  scheduler wants a swap.
- proc_swap  out  1  one-cycle swap strobe to the keeper.
- new_proc_num  out  PROC_WIDTH  process to load.
- cur_proc  out  PROC_WIDTH  scheduler's view of the executing process.
- ready_mask  out  NUM_PROCS  ready table.
- idle  out  1  no user process ready.

Behaviour:
- Reset (sync, rst=1 at the clock edge), from any state:
  - state=RUN, cur_proc=0, new_proc_num=0, swap_req=0, proc_swap=0.
  - ready_mask = only bit 0 set; quantum counter = QUANTUM; saved_proc=0; idle=1.
- Ready table:
  - Bit 0 is hardwired 1.
  - Set and clr on the same proc_id in the same cycle: clr wins.
  - proc_id=0 or proc_id ≥ NUM_PROCS: ignored.
  - Updates take effect on the next edge.
- Selection: round-robin search from cur_proc+1 upward, wrapping, skipping 0; the first ready index wins. If none is found, select 0. idle = no ready bit in 1..NUM_PROCS-1.
- States: RUN, REQ, SWAP, KERNEL.
- RUN:
  - Quantum counter decrements every cycle.
  - Trigger = counter reaches 1, or yield, or cur_proc's ready bit cleared.
  - On trigger, compute next. If next==cur_proc, reload QUANTUM and stay in RUN with no swap. Otherwise latch new_proc_num=next and go to REQ.
- REQ:
  - swap_req=1, new_proc_num held stable.
  - If new_proc_num's ready bit is cleared while waiting, re-select on the next cycle.
  - On swap_ack go to SWAP.
- SWAP (exactly one cycle):
  - proc_swap=1, swap_req=0.
  - cur_proc←new_proc_num, quantum reloaded, → RUN.
  - Latency is swap_ack at edge N → proc_swap high in cycle N+1 → cur_proc updated at edge N+1.
- KERNEL:
  - Entered when true_intrpt=1 in any state; highest priority after rst.
  - saved_proc←cur_proc, or ←new_proc_num if the interrupt hits SWAP.
  - cur_proc←0, swap_req/proc_swap dropped, pending request aborted.
  - The counter is frozen while in KERNEL.
  - On intrpt_done: if saved_proc≠0 and still ready, new_proc_num=saved_proc; otherwise use a round-robin pick starting from saved_proc. Then → REQ.
  - If that pick is 0 (idle), stay in RUN on process 0 with no request.
- Simultaneous events:
  - true_intrpt beats swap_ack, yield and expiry.
  - yield in the same cycle as expiry counts as one trigger.
  - yield outside RUN is ignored.
- proc_swap is never asserted without a preceding swap_req cycle, and never with new_proc_num==cur_proc.

Optional Feature:
- SCHED_QUANTUM_CFG_EN defined:
  - Adds ports cfg_quantum_we (in, 1) and cfg_quantum (in, QWIDTH).
  - A write updates the reload register, which resets to QUANTUM.
  - The new value applies at the next reload. The running slice is unchanged.
  - A write of 0 is ignored.
- Not defined: the reload value is the constant QUANTUM and the ports are absent.

Decomposition:
- Package proc_sched_pkg holds:
  - the state enum (RUN/REQ/SWAP/KERNEL);
  - the KERNEL_PROC=0 constant;
  - a function that returns the default quantum.
- One sub-module, rr_picker: combinational round-robin priority search. Inputs are ready_mask and start index; outputs are next index and found flag.

Test Plan:
- Reset, then set procs 3 and 5 ready, QUANTUM=4:
  - swap_req rises within 4 cycles with new_proc_num=3.
  - swap_ack → proc_swap one cycle later, then cur_proc=3.
  - At the next expiry new_proc_num=5, then wrap to 3.
- Only proc 7 ready and running:
  - Expiry reloads the quantum.
  - swap_req and proc_swap stay 0.
- Running 3, with 5 ready:
  - yield → REQ for 5.
  - Hold swap_ack low for 10 cycles: swap_req stays 1 and new_proc_num stays 5.
  - Ack → swap.
- true_intrpt while in REQ (3→5):
  - cur_proc=0, swap_req=0 next cycle.
  - intrpt_done → REQ with new_proc_num=3 (saved_proc).
  - Repeat with proc 3 cleared during KERNEL → new_proc_num=5.
- Same-cycle set and clr on proc 9 → bit 9 stays 0.
  - clr on proc_id 0 → bit 0 stays 1.
  - Clear the running process's bit → immediate REQ, or idle=1 with a request for 0.
- With SCHED_QUANTUM_CFG_EN, write cfg_quantum=2 mid-slice:
  - The current slice completes at the old length.
  - The next slice is 2 cycles.
  - A write of 0 is ignored.
